dp_ram_param: RTL and testbench
===============================

# dp_ram_param

Parametrised synchronous dual-port RAM, successor to the fixed 512x8 one-write/one-read memory. Both ports read and write, and width, depth, read-during-write policy and output latency are set by parameters. A built-in clear sequencer zeroes the array after reset. Used as the general-purpose on-chip buffer for line buffers, lookup tables and inter-block mailboxes.

## Interface
- `DATA_W`, default 8: word width in bits.
- `ADDR_W`, default 9: address width. Depth is `2**ADDR_W`.
- `RDW_MODE`, default 0: same-address read of port B during a write on port A.
  - 0 = READ_FIRST: B returns the old word.
  - 1 = WRITE_FIRST: B returns the new word.
- `OUT_REG`, default 0: read latency.
  - 0 = one cycle.
  - 1 = two cycles, with an extra output register.
- `CLEAR_ON_RESET`, default 1: when 1, the array is zeroed after reset.

Ports:
- `clk` in 1: single clock. All logic is on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `cs` in 1: chip select. When low, no new access is accepted.
- `en_a` in 1: port A access request.
- `we_a` in 1: port A write (1) or read (0).
- `addr_a` in `ADDR_W`: port A address.
- `din_a` in `DATA_W`: port A write data.
- `dout_a` out `DATA_W`: port A read data.
- `valid_a` out 1: one-cycle pulse when `dout_a` carries fresh read data.
- `en_b`, `we_b`, `addr_b`, `din_b`, `dout_b`, `valid_b`: identical set for port B.
- `busy` out 1: clear sequence in progress. All accesses are ignored while high.

## Operation
- Access accepted on a port at edge T when `cs & en_x & ~busy`.
- Accepted write: `mem[addr] <= din`.
  - `dout_x` is unchanged and `valid_x` stays low.
- Accepted read: `dout_x` is loaded with the word after the latency below, and `valid_x` pulses with it.
- `dout_x` holds its last value between reads.
- Both ports write the same address in the same cycle: port A wins and port B's write is dropped.
- Read and write on the same address in the same cycle (either port combination): governed by `RDW_MODE` as above.
- Both ports read the same address: both return the same word.
- Clear FSM has two states, CLEAR and READY.
  - Reset enters CLEAR if `CLEAR_ON_RESET`=1, otherwise READY.
  - In CLEAR, a counter writes 0 to addresses 0..`2**ADDR_W`-1, one per cycle, with `busy`=1.
  - After the last address the FSM moves to READY, where `busy`=0.
  - READY is terminal until the next reset.
- Reset mid-clear restarts the counter at 0.
- Reset mid-read: the pending read is discarded.
- `cs` gates only new accesses. With `OUT_REG`=1, a read already in flight in stage 2 still completes and pulses `valid_x`.
- Array contents are not reset when `CLEAR_ON_RESET`=0.

## Timing
- Reset values: `dout_a`=`dout_b`=0, `valid_a`=`valid_b`=0, `busy`=`CLEAR_ON_RESET`, clear counter 0.
- `OUT_REG`=0: read accepted at edge T gives data and `valid` after edge T+1.
- `OUT_REG`=1: data and `valid` appear after edge T+2.
- Back-to-back reads on every cycle give one result per cycle, with no bubbles.
- A write at edge T is visible to a read accepted at edge T+1 on either port.
- Clear duration:
  - `busy` rises asynchronously with `rst`.
  - `busy` falls after `2**ADDR_W` edges following `rst` deassertion (512 edges at defaults).
  - The first access is accepted on the edge where `busy` is already 0.

## Structure
- Shared package `dp_ram_pkg` holds:
  - constants `RDW_READ_FIRST`=0 and `RDW_WRITE_FIRST`=1;
  - the clear-FSM state type {CLEAR, READY}.
- Sub-module `dp_ram_clear_fsm` contains the state, address counter and `busy` logic. It drives a write-override (address and zero data) into the port A write path.
- The array and the port logic stay in the top level as a single memory.

## Test plan
- Clear: reset with defaults, then read addresses 0, 255 and 511 after `busy` falls → all return 0x00.
  - `busy` is high for exactly 512 cycles.
  - Requests issued during `busy` produce no `valid`.
- Basic R/W: A writes 0x5A to address 10, then B reads 10 on the next cycle → `dout_b`=0x5A one cycle later (`OUT_REG`=0) with a single `valid_b` pulse; `dout_a` is unchanged.
- Write collision: A writes 0x11 and B writes 0x22 to address 7 in the same cycle, then A reads 7 → 0x11.
- Read-during-write: `mem[3]`=0xAA, then A writes 0xBB while B reads 3.
  - `RDW_MODE`=0 → 0xAA.
  - `RDW_MODE`=1 → 0xBB.
- Pipeline with `OUT_REG`=1 and `DATA_W`=16: read addresses 0..3 back-to-back, dropping `cs` after the last issue → four `valid` pulses with data 2 cycles after each request, in order.
- Reset mid-clear: assert `rst` at clear counter 100 → counter restarts at 0 and `busy` lasts a full 512 cycles after release.

Source files
------------

// File: rtl/dp_ram_pkg.sv
// Shared definitions for the parametrised dual-port RAM: read-during-write
// policy codes and the clear-sequencer state type.
package dp_ram_pkg;

    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;

    typedef enum logic {
        CLEAR,
        READY
    } clr_state_t;

endpackage

// File: rtl/dp_ram_clear_fsm.sv
// Post-reset clear sequencer: walks every address once writing zero, holding
// busy high until the walk completes.
module dp_ram_clear_fsm
    import dp_ram_pkg::*;
#(
    parameter int ADDR_W         = 9,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              rst,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    clr_state_t        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if (CLEAR_ON_RESET != 0) begin
                state_q <= CLEAR;
            end else begin
                state_q <= READY;
            end
            cnt_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy    = 1'b0;
        clr_we  = 1'b0;
        case (state_q)
            CLEAR: begin
                busy   = 1'b1;
                clr_we = 1'b1;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST_ADDR) begin
                    state_d = READY;
                end
            end
            READY: begin
                state_d = READY;
            end
            default: begin
                state_d = READY;
            end
        endcase
    end

    assign clr_addr = cnt_q;

endmodule

// File: rtl/dp_ram_param.sv
// Parametrised synchronous dual-port RAM with selectable read-during-write
// policy, optional extra output register and post-reset zero fill.
module dp_ram_param
    import dp_ram_pkg::*;
#(
    parameter int DATA_W         = 8,
    parameter int ADDR_W         = 9,
    parameter int RDW_MODE       = RDW_READ_FIRST,
    parameter int OUT_REG        = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs,
    input  logic              en_a,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] din_a,
    output logic [DATA_W-1:0] dout_a,
    output logic              valid_a,
    input  logic              en_b,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] din_b,
    output logic [DATA_W-1:0] dout_b,
    output logic              valid_b,
    output logic              busy
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;

    dp_ram_clear_fsm #(
        .ADDR_W        (ADDR_W),
        .CLEAR_ON_RESET(CLEAR_ON_RESET)
    ) u_clear (
        .clk     (clk),
        .rst     (rst),
        .busy    (busy),
        .clr_we  (clr_we),
        .clr_addr(clr_addr)
    );

    logic acc_a, acc_b, rd_a, rd_b, wr_a, wr_b;

    assign acc_a = cs & en_a & ~busy;
    assign acc_b = cs & en_b & ~busy;
    assign rd_a  = acc_a & ~we_a;
    assign wr_a  = acc_a &  we_a;
    assign rd_b  = acc_b & ~we_b;
    assign wr_b  = acc_b &  we_b;

    // The clear sequencer borrows the port A write path; port B loses any
    // same-address write collision against it.
    logic              mem_we_a, mem_we_b;
    logic [ADDR_W-1:0] mem_addr_a;
    logic [DATA_W-1:0] mem_din_a;

    assign mem_we_a   = clr_we | wr_a;
    assign mem_addr_a = clr_we ? clr_addr : addr_a;
    assign mem_din_a  = clr_we ? '0 : din_a;
    assign mem_we_b   = wr_b & ~(mem_we_a & (addr_b == mem_addr_a));

    always_ff @(posedge clk) begin
        if (mem_we_a) begin
            mem[mem_addr_a] <= mem_din_a;
        end
        if (mem_we_b) begin
            mem[addr_b] <= mem_din_b_unused_guard(din_b);
        end
    end

    function automatic logic [DATA_W-1:0] mem_din_b_unused_guard(input logic [DATA_W-1:0] d);
        return d;
    endfunction

    logic fwd_a, fwd_b;

    assign fwd_a = (RDW_MODE == RDW_WRITE_FIRST) && mem_we_b && (addr_b == addr_a);
    assign fwd_b = (RDW_MODE == RDW_WRITE_FIRST) && mem_we_a && (mem_addr_a == addr_b);

    // Stage p0: array read at the accepting edge
    logic [DATA_W-1:0] rdata_a_p0, rdata_b_p0;
    logic              vld_a_p0, vld_b_p0;

    always_ff @(posedge clk) begin
        if (rd_a) begin
            rdata_a_p0 <= fwd_a ? din_b : mem[addr_a];
        end
        if (rd_b) begin
            rdata_b_p0 <= fwd_b ? mem_din_a : mem[addr_b];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_a_p0 <= 1'b0;
            vld_b_p0 <= 1'b0;
        end else begin
            vld_a_p0 <= rd_a;
            vld_b_p0 <= rd_b;
        end
    end

    logic [DATA_W-1:0] rdata_a_pl, rdata_b_pl;
    logic              vld_a_pl, vld_b_pl;

    generate
        if (OUT_REG != 0) begin : g_out_reg
            // Stage p1: optional extra register, independent of cs
            logic [DATA_W-1:0] rdata_a_p1, rdata_b_p1;
            logic              vld_a_p1, vld_b_p1;

            always_ff @(posedge clk) begin
                if (vld_a_p0) begin
                    rdata_a_p1 <= rdata_a_p0;
                end
                if (vld_b_p0) begin
                    rdata_b_p1 <= rdata_b_p0;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld_a_p1 <= 1'b0;
                    vld_b_p1 <= 1'b0;
                end else begin
                    vld_a_p1 <= vld_a_p0;
                    vld_b_p1 <= vld_b_p0;
                end
            end

            assign rdata_a_pl = rdata_a_p1;
            assign rdata_b_pl = rdata_b_p1;
            assign vld_a_pl   = vld_a_p1;
            assign vld_b_pl   = vld_b_p1;
        end else begin : g_no_out_reg
            assign rdata_a_pl = rdata_a_p0;
            assign rdata_b_pl = rdata_b_p0;
            assign vld_a_pl   = vld_a_p0;
            assign vld_b_pl   = vld_b_p0;
        end
    endgenerate

    // Output stage: dout holds its value between reads
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_a  <= '0;
            dout_b  <= '0;
            valid_a <= 1'b0;
            valid_b <= 1'b0;
        end else begin
            valid_a <= vld_a_pl;
            valid_b <= vld_b_pl;
            if (vld_a_pl) begin
                dout_a <= rdata_a_pl;
            end
            if (vld_b_pl) begin
                dout_b <= rdata_b_pl;
            end
        end
    end

endmodule

// File: tb/tb_dp_ram_param.sv
// Scoreboard bench for dp_ram_param: three instances (defaults, write-first,
// 16-bit with output register) share one directed stimulus stream.
module tb_dp_ram_param;

    logic        clk = 1'b0;
    logic        rst;
    logic        cs, en_a, we_a, en_b, we_b;
    logic [8:0]  addr_a, addr_b;
    logic [15:0] din_a, din_b;

    logic [7:0]  dout_a0, dout_b0, dout_a1, dout_b1;
    logic [15:0] dout_a2, dout_b2;
    logic        valid_a0, valid_b0, valid_a1, valid_b1, valid_a2, valid_b2;
    logic        busy0, busy1, busy2;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    dp_ram_param #(.DATA_W(8), .ADDR_W(9), .RDW_MODE(0), .OUT_REG(0), .CLEAR_ON_RESET(1)) u0 (
        .clk(clk), .rst(rst), .cs(cs),
        .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a[7:0]), .dout_a(dout_a0), .valid_a(valid_a0),
        .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .din_b(din_b[7:0]), .dout_b(dout_b0), .valid_b(valid_b0),
        .busy(busy0));

    dp_ram_param #(.DATA_W(8), .ADDR_W(9), .RDW_MODE(1), .OUT_REG(0), .CLEAR_ON_RESET(1)) u1 (
        .clk(clk), .rst(rst), .cs(cs),
        .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a[7:0]), .dout_a(dout_a1), .valid_a(valid_a1),
        .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .din_b(din_b[7:0]), .dout_b(dout_b1), .valid_b(valid_b1),
        .busy(busy1));

    dp_ram_param #(.DATA_W(16), .ADDR_W(9), .RDW_MODE(0), .OUT_REG(1), .CLEAR_ON_RESET(1)) u2 (
        .clk(clk), .rst(rst), .cs(cs),
        .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a), .dout_a(dout_a2), .valid_a(valid_a2),
        .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .din_b(din_b), .dout_b(dout_b2), .valid_b(valid_b2),
        .busy(busy2));

    logic [15:0] obs_d [3][2];
    logic        obs_v [3][2];

    assign obs_d[0][0] = {8'h00, dout_a0};
    assign obs_d[0][1] = {8'h00, dout_b0};
    assign obs_d[1][0] = {8'h00, dout_a1};
    assign obs_d[1][1] = {8'h00, dout_b1};
    assign obs_d[2][0] = dout_a2;
    assign obs_d[2][1] = dout_b2;
    assign obs_v[0][0] = valid_a0;
    assign obs_v[0][1] = valid_b0;
    assign obs_v[1][0] = valid_a1;
    assign obs_v[1][1] = valid_b1;
    assign obs_v[2][0] = valid_a2;
    assign obs_v[2][1] = valid_b2;

    typedef struct {
        int          inst;
        int          port;
        int          due;
        logic [15:0] data;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    logic [15:0] ref_mem [512];

    // Output checker: every valid pulse must match a scoreboard entry due now.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            for (int p = 0; p < 2; p++) begin
                int          idx;
                logic        ev;
                logic [15:0] ed;
                idx = -1;
                ed  = 16'h0000;
                for (int k = 0; k < sb.size(); k++) begin
                    if (idx < 0 && sb[k].inst == i && sb[k].port == p && sb[k].due == cyc) idx = k;
                end
                ev = (idx >= 0);
                if (ev) ed = sb[idx].data;
                if (ev || obs_v[i][p] !== 1'b0) begin
                    tests++;
                    assert (obs_v[i][p] === ev) else begin
                        fails++;
                        $error("FAIL valid u%0d port%0d cyc%0d: observed %b expected %b", i, p, cyc, obs_v[i][p], ev);
                    end
                end
                if (ev) begin
                    if (obs_v[i][p] === 1'b1) begin
                        tests++;
                        assert (obs_d[i][p] === ed) else begin
                            fails++;
                            $error("FAIL dout u%0d port%0d cyc%0d: observed 0x%0h expected 0x%0h", i, p, cyc, obs_d[i][p], ed);
                        end
                    end
                    sb.delete(idx);
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus; acc says whether the bench expects the RAM
    // to be out of its clear sequence at the next edge.
    task automatic op(input logic c,
                      input logic ea, input logic wa, input logic [8:0] aa, input logic [15:0] da,
                      input logic eb, input logic wb, input logic [8:0] ab, input logic [15:0] db,
                      input logic acc);
        logic        ra, xa, rb, xb;
        logic [15:0] old_v, new_v;
        cs = c; en_a = ea; we_a = wa; addr_a = aa; din_a = da;
        en_b = eb; we_b = wb; addr_b = ab; din_b = db;
        ra = acc & c & ea & ~wa;
        xa = acc & c & ea &  wa;
        rb = acc & c & eb & ~wb;
        xb = acc & c & eb &  wb;
        if (ra) begin
            old_v = ref_mem[aa];
            new_v = (xb && ab == aa) ? db : old_v;
            sb.push_back('{0, 0, cyc + 2, {8'h00, old_v[7:0]}});
            sb.push_back('{1, 0, cyc + 2, {8'h00, new_v[7:0]}});
            sb.push_back('{2, 0, cyc + 3, old_v});
        end
        if (rb) begin
            old_v = ref_mem[ab];
            new_v = (xa && aa == ab) ? da : old_v;
            sb.push_back('{0, 1, cyc + 2, {8'h00, old_v[7:0]}});
            sb.push_back('{1, 1, cyc + 2, {8'h00, new_v[7:0]}});
            sb.push_back('{2, 1, cyc + 3, old_v});
        end
        if (xa) ref_mem[aa] = da;
        if (xb && !(xa && aa == ab)) ref_mem[ab] = db;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) op(1'b0, 1'b0, 1'b0, 9'd0, 16'h0, 1'b0, 1'b0, 9'd0, 16'h0, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst = 1'b1; cs = 1'b0; en_a = 1'b0; we_a = 1'b0; addr_a = '0; din_a = '0;
        en_b = 1'b0; we_b = 1'b0; addr_b = '0; din_b = '0;
        foreach (ref_mem[i]) ref_mem[i] = 16'h0000;
        repeat (3) @(negedge clk);

        check("rst_busy0", busy0, 1);
        check("rst_busy2", busy2, 1);
        check("rst_dout_a0", dout_a0, 0);
        check("rst_valid_b0", valid_b0, 0);
        check("rst_dout_b2", dout_b2, 0);

        // Clear: count busy cycles while hammering both ports
        rst = 1'b0;
        k = 0;
        while (busy0 === 1'b1 && k < 2000) begin
            op(1'b1, 1'b1, 1'b0, k[8:0], 16'h0, 1'b1, 1'b1, k[8:0], 16'hFFFF, 1'b0);
            k++;
        end
        check("busy_len", k, 512);
        check("busy1_low", busy1, 0);
        check("busy2_low", busy2, 0);
        idle(4);

        op(1'b1, 1'b1, 1'b0, 9'd0,   16'h0, 1'b1, 1'b0, 9'd255, 16'h0, 1'b1);
        op(1'b1, 1'b1, 1'b0, 9'd511, 16'h0, 1'b0, 1'b0, 9'd0,   16'h0, 1'b1);
        idle(4);

        // Write collision, then basic cross-port R/W
        op(1'b1, 1'b1, 1'b1, 9'd7, 16'h0011, 1'b1, 1'b1, 9'd7, 16'h0022, 1'b1);
        op(1'b1, 1'b1, 1'b0, 9'd7, 16'h0,    1'b0, 1'b0, 9'd0, 16'h0,    1'b1);
        idle(4);
        op(1'b1, 1'b1, 1'b1, 9'd10, 16'h005A, 1'b0, 1'b0, 9'd0,  16'h0, 1'b1);
        op(1'b1, 1'b0, 1'b0, 9'd0,  16'h0,    1'b1, 1'b0, 9'd10, 16'h0, 1'b1);
        idle(4);
        check("dout_a0_hold", dout_a0, 8'h11);
        check("dout_b0_rw", dout_b0, 8'h5A);

        // Read-during-write in both port directions
        op(1'b1, 1'b1, 1'b1, 9'd3, 16'h00AA, 1'b0, 1'b0, 9'd0, 16'h0, 1'b1);
        op(1'b1, 1'b1, 1'b1, 9'd3, 16'h00BB, 1'b1, 1'b0, 9'd3, 16'h0, 1'b1);
        idle(4);
        check("rdw_rf_b0", dout_b0, 8'hAA);
        check("rdw_wf_b1", dout_b1, 8'hBB);
        op(1'b1, 1'b0, 1'b0, 9'd0, 16'h0, 1'b1, 1'b1, 9'd4, 16'h0033, 1'b1);
        op(1'b1, 1'b1, 1'b0, 9'd4, 16'h0, 1'b1, 1'b1, 9'd4, 16'h0044, 1'b1);
        idle(4);
        check("rdw_wf_a1", dout_a1, 8'h44);

        // Back-to-back reads, then cs dropped with requests still asserted
        for (int i = 0; i < 4; i++) begin
            op(1'b1, 1'b1, 1'b1, 9'(20 + i), 16'h1200 + 16'(i) * 16'h0111, 1'b0, 1'b0, 9'd0, 16'h0, 1'b1);
        end
        for (int i = 0; i < 4; i++) begin
            op(1'b1, 1'b1, 1'b0, 9'(20 + i), 16'h0, 1'b1, 1'b0, 9'(23 - i), 16'h0, 1'b1);
        end
        op(1'b0, 1'b1, 1'b0, 9'd20, 16'h0, 1'b1, 1'b0, 9'd21, 16'h0, 1'b1);
        op(1'b0, 1'b1, 1'b0, 9'd22, 16'h0, 1'b1, 1'b0, 9'd23, 16'h0, 1'b1);
        idle(5);
        check("pipe_last_a2", dout_a2, 16'h1533);
        check("pipe_last_b2", dout_b2, 16'h1200);

        // Reset while a read is pending discards it
        op(1'b1, 1'b1, 1'b0, 9'd3, 16'h0, 1'b0, 1'b0, 9'd0, 16'h0, 1'b1);
        cs = 1'b0; en_a = 1'b0;
        rst = 1'b1;
        sb.delete();
        #1;
        check("midread_dout_a0", dout_a0, 0);
        check("midread_busy0", busy0, 1);
        repeat (3) @(negedge clk);
        check("midread_valid_a0", valid_a0, 0);
        check("midread_valid_a2", valid_a2, 0);

        // Reset mid-clear at counter 100 restarts the full sweep
        rst = 1'b0;
        idle(100);
        rst = 1'b1;
        #1;
        check("midclear_busy0", busy0, 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        foreach (ref_mem[i]) ref_mem[i] = 16'h0000;
        k = 0;
        while (busy0 === 1'b1 && k < 2000) begin
            op(1'b1, 1'b1, 1'b0, 9'd3, 16'h0, 1'b1, 1'b0, 9'd10, 16'h0, 1'b0);
            k++;
        end
        check("busy_len_restart", k, 512);

        op(1'b1, 1'b1, 1'b0, 9'd3,  16'h0, 1'b1, 1'b0, 9'd10, 16'h0, 1'b1);
        op(1'b1, 1'b1, 1'b0, 9'd21, 16'h0, 1'b1, 1'b0, 9'd7,  16'h0, 1'b1);
        idle(5);
        check("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
